// File: rtl/pipeline_5_mem_stage.sv
// -----------------------------------------------------------------------------
// pipeline_5_mem_stage
//   Memory-access stage of the 5-stage pipeline. Consumes the stage-3/4 latch
//   outputs and performs loads and stores against an internal 64-bit data
//   memory. It also produces the registered stage-4/5 write-back bundle.
//   Loads longer than one cycle hold the upstream latches through 'stall'.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   dbusWire3     ALU result or byte address (64)
//   bbusWire4     store data (64)
//   DselectWire4  one-hot destination register select (32)
//   lwSwFlag4     01 load, 10 store, 00/11 ALU pass-through
//   NOPWire3      incoming bundle is a bubble
//   dbusWire4     write-back data (64, registered)
//   DselectWire5  write-back register select, 0 = no write (32, registered)
//   NOPWire4      outgoing bundle is a bubble (registered)
//   stall         upstream must hold its bundle (registered)
//   alignErr      one-cycle pulse on a misaligned load or store (registered)
// -----------------------------------------------------------------------------
module pipeline_5_mem_stage #(
  parameter int ADDR_W   = 8,
  parameter int LOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] dbusWire3,
  input  logic [63:0] bbusWire4,
  input  logic [31:0] DselectWire4,
  input  logic [1:0]  lwSwFlag4,
  input  logic        NOPWire3,
  output logic [63:0] dbusWire4,
  output logic [31:0] DselectWire5,
  output logic        NOPWire4,
  output logic        stall,
  output logic        alignErr
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(LOAD_LAT - 1);

  logic [63:0]       mem_r [DEPTH];
  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [ADDR_W-1:0] cap_idx_r, cap_idx_s;
  logic [31:0]       cap_sel_r, cap_sel_s;

  logic [ADDR_W-1:0] idx_s;
  logic              misaligned_s;
  logic              we_s;
  logic [63:0]       dbus_s;
  logic [31:0]       dsel_s;
  logic              nop_s;
  logic              stall_s;
  logic              align_s;

  // Upper address bits are dropped so addresses wrap modulo the memory depth.
  assign idx_s        = dbusWire3[ADDR_W+2:3];
  assign misaligned_s = (dbusWire3[2:0] != 3'b000);

  // Next-state and next-output decode; every path starts from a bubble.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    cap_idx_s = cap_idx_r;
    cap_sel_s = cap_sel_r;
    we_s      = 1'b0;
    dbus_s    = 64'd0;
    dsel_s    = 32'd0;
    nop_s     = 1'b1;
    stall_s   = 1'b0;
    align_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (NOPWire3) begin
          nop_s = 1'b1;
        end else begin
          case (lwSwFlag4)
            2'b01: begin
              if (misaligned_s) begin
                align_s = 1'b1;
              end else if (LOAD_LAT == 1) begin
                dbus_s = mem_r[idx_s];
                dsel_s = DselectWire4;
                nop_s  = 1'b0;
              end else begin
                cap_idx_s = idx_s;
                cap_sel_s = DselectWire4;
                cnt_s     = WAIT_INIT;
                state_s   = LOAD_WAIT;
                stall_s   = 1'b1;
              end
            end
            2'b10: begin
              if (misaligned_s) begin
                align_s = 1'b1;
              end else begin
                we_s   = 1'b1;
                dbus_s = dbusWire3;
                dsel_s = 32'd0;
                nop_s  = 1'b0;
              end
            end
            default: begin
              dbus_s = dbusWire3;
              dsel_s = DselectWire4;
              nop_s  = 1'b0;
            end
          endcase
        end
      end
      LOAD_WAIT: begin
        // Memory is read at the result edge so any earlier store is visible.
        if (cnt_r == 4'd1) begin
          dbus_s  = mem_r[cap_idx_r];
          dsel_s  = cap_sel_r;
          nop_s   = 1'b0;
          cnt_s   = 4'd0;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          stall_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Pipeline state and the registered write-back bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      cap_idx_r    <= '0;
      cap_sel_r    <= 32'd0;
      dbusWire4    <= 64'd0;
      DselectWire5 <= 32'd0;
      NOPWire4     <= 1'b1;
      stall        <= 1'b0;
      alignErr     <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      cap_idx_r    <= cap_idx_s;
      cap_sel_r    <= cap_sel_s;
      dbusWire4    <= dbus_s;
      DselectWire5 <= dsel_s;
      NOPWire4     <= nop_s;
      stall        <= stall_s;
      alignErr     <= align_s;
    end
  end

  // Data memory write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rst_n && we_s) begin
      mem_r[idx_s] <= bbusWire4;
    end
  end

endmodule
